pe_gin_fifo: RTL and testbench
==============================

PE_GIN_FIFO -- requirements
Module: pe_gin_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of one GIN payload word.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-003 Parameter CNT_WIDTH, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_in  input  DATA_WIDTH  payload from the upstream multicast controller's data_out.
REQ-007 enable_in  input  1  write strobe from the multicast controller's enable_out.
REQ-008 ready_out  output  1  space available; drives the multicast controller's ready_in.
REQ-009 data_out  output  DATA_WIDTH  head-of-queue word to the PE datapath.
REQ-010 valid_out  output  1  head-of-queue word is valid.
REQ-011 ready_in  input  1  PE accepts the head word this cycle.
REQ-012 count  output  CNT_WIDTH  current number of stored entries.
REQ-013 overflow  output  1  sticky error flag for a write attempted while full.

Function
REQ-014 The block SHALL be a DEPTH-entry FIFO with write pointer wr_ptr, read pointer rd_ptr, and occupancy counter cnt, all registered.
REQ-015 ready_out SHALL equal (cnt != DEPTH) and depend only on registered state.
  - It has no combinational path from enable_in or ready_in.
REQ-016 A write SHALL occur when enable_in && ready_out.
  - data_in is stored at wr_ptr.
  - wr_ptr advances by 1, modulo DEPTH.
REQ-017 valid_out SHALL equal (cnt != 0).
REQ-018 data_out SHALL equal the entry at rd_ptr when valid_out=1, and all zeros otherwise.
REQ-019 A read SHALL occur when valid_out && ready_in; rd_ptr advances by 1, modulo DEPTH.
REQ-020 Write-to-read latency SHALL be exactly 1 cycle.
  - A word written in cycle N is visible on data_out with valid_out=1 in cycle N+1 when the FIFO was empty.
  - There is no combinational bypass.
REQ-021 cnt SHALL update each cycle as follows:
  - write and read in the same cycle: unchanged.
  - write only: +1.
  - read only: -1.
  - neither: unchanged.
REQ-022 When full (cnt=DEPTH), a write SHALL be refused even if a read occurs in the same cycle.
  - The read completes and cnt becomes DEPTH-1.
REQ-023 When empty (cnt=0), ready_in SHALL have no effect; pointers and cnt stay unchanged.
REQ-024 When empty, a simultaneous write SHALL store the word, and cnt becomes 1.
REQ-025 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless; order is preserved across wrap.
REQ-026 overflow SHALL set to 1 on any cycle with enable_in=1 and ready_out=0.
  - It remains 1 until reset.
  - The offending data is discarded, and FIFO contents and pointers are unchanged.
REQ-027 count SHALL equal cnt and never exceed DEPTH.
REQ-028 Storage entries SHALL NOT be cleared on reset; only pointers, cnt and overflow are reset.

Reset
REQ-029 While reset=1 at a rising edge, the following SHALL be set to 0:
  - wr_ptr and rd_ptr
  - cnt
  - overflow
REQ-030 After reset the outputs SHALL be ready_out=1, valid_out=0, data_out=0, count=0, overflow=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries.
  - Writes and reads presented in the reset cycle are ignored.
REQ-032 The first write accepted in the cycle after reset deasserts SHALL be stored normally.

Verification
REQ-033 Single word: after reset, write 0xA5A5 with ready_in=0.
  - Next cycle: valid_out=1, data_out=0xA5A5, count=1.
  - Then ready_in=1 for one cycle, giving valid_out=0, data_out=0, count=0.
REQ-034 Fill and overflow (DEPTH=4): write 1,2,3,4 with ready_in=0.
  - Result: ready_out=0, count=4.
  - Then write 5, giving overflow=1 and count=4.
  - Draining then reads 1,2,3,4 in order.
REQ-035 Full with simultaneous read/write: at count=4, assert enable_in (data 9) and ready_in together.
  - Head 1 is consumed and 9 is not stored.
  - count=3, overflow=1.
REQ-036 Streaming wrap: enable_in=1 and ready_in=1 continuously for 10 cycles with data 1..10.
  - Outputs are 1..10 in order, each one cycle after its write.
  - count stays at or below 1, and no overflow.
REQ-037 Mid-operation reset: with count=3, assert reset for one cycle while enable_in=1.
  - Result: count=0, valid_out=0, ready_out=1, overflow=0.
  - The next write of 0x77 appears at data_out one cycle later.

Source files
------------

// File: rtl/pe_gin_fifo_if.sv
// GIN delivery channel between the multicast controller, the PE input FIFO and the PE datapath.
// The slave modport is the FIFO's view; the master modport is the surrounding logic's view.
interface pe_gin_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  enable_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;

    modport slave (
        input  data_in,
        input  enable_in,
        input  ready_in,
        output ready_out,
        output data_out,
        output valid_out,
        output count,
        output overflow
    );

    modport master (
        output data_in,
        output enable_in,
        output ready_in,
        input  ready_out,
        input  data_out,
        input  valid_out,
        input  count,
        input  overflow
    );
endinterface

// File: rtl/pe_gin_fifo.sv
// DEPTH-entry input FIFO between the GIN multicast controller and a PE datapath.
// Ready/valid outputs come from registered state only; a sticky flag records any write attempted while full.
module pe_gin_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    pe_gin_fifo_if.slave     bus
);
    localparam int                   PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  overflow_q;
    logic                  not_full;
    logic                  not_empty;
    logic                  do_write;
    logic                  do_read;

    assign not_full  = (cnt != FULL_CNT);
    assign not_empty = (cnt != '0);
    assign do_write  = bus.enable_in && not_full;
    assign do_read   = not_empty && bus.ready_in;

    assign bus.ready_out = not_full;
    assign bus.valid_out = not_empty;
    assign bus.data_out  = not_empty ? mem[rd_ptr] : '0;
    assign bus.count     = cnt;
    assign bus.overflow  = overflow_q;

    // Storage has no reset; a write presented during reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({do_write, do_read})
                2'b10:   cnt <= cnt + CNT_WIDTH'(1);
                2'b01:   cnt <= cnt - CNT_WIDTH'(1);
                default: cnt <= cnt;
            endcase
            if (bus.enable_in && !not_full) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_gin_fifo.sv
// Scenario-driven bench for pe_gin_fifo: a queue scoreboard holds accepted words in order
// and every read is compared against the popped head.
module tb_pe_gin_fifo;
    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 4;
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [DATA_WIDTH-1:0] sb [$];
    logic                  mdl_ovf;

    pe_gin_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    pe_gin_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset(input logic en, input logic rdy);
        reset         = 1'b1;
        bus.enable_in = en;
        bus.ready_in  = rdy;
        bus.data_in   = 64'hEEEE;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.enable_in = 1'b0;
        bus.ready_in  = 1'b0;
        bus.data_in   = '0;
        sb.delete();
        mdl_ovf = 1'b0;
    endtask

    // One clock of stimulus; scoreboard push/pop follows the FIFO rules from the bench's own occupancy.
    task automatic applyStimulus(input logic en, input logic [DATA_WIDTH-1:0] d, input logic rdy,
                                 output logic did_read, output logic [DATA_WIDTH-1:0] obs,
                                 output logic [DATA_WIDTH-1:0] exp_w);
        logic full;
        bus.enable_in = en;
        bus.data_in   = d;
        bus.ready_in  = rdy;
        full     = (sb.size() == DEPTH);
        did_read = (sb.size() != 0) && rdy;
        obs      = bus.data_out;
        exp_w    = '0;
        if (did_read) exp_w = sb.pop_front();
        if (en && !full) sb.push_back(d);
        if (en && full) mdl_ovf = 1'b1;
        @(posedge clk);
        #1;
        bus.enable_in = 1'b0;
        bus.ready_in  = 1'b0;
        bus.data_in   = '0;
    endtask

    task automatic test_reset();
        doReset(1'b0, 1'b0);
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b need 1", bus.ready_out); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b need 0", bus.valid_out); end
        checks++; if (bus.data_out !== '0) begin errors++; $display("[TB] FAIL reset_data got %h need 0", bus.data_out); end
        checks++; if (bus.count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d need 0", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b need 0", bus.overflow); end
    endtask

    task automatic test_single_word();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w;
        doReset(1'b0, 1'b0);
        applyStimulus(1'b1, 64'hA5A5, 1'b0, rd, obs, exp_w);
        checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b need 1", bus.valid_out); end
        checks++; if (bus.data_out !== 64'hA5A5) begin errors++; $display("[TB] FAIL single_data got %h need a5a5", bus.data_out); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL single_count got %0d need 1", bus.count); end
        applyStimulus(1'b0, '0, 1'b1, rd, obs, exp_w);
        checks++; if (!rd || obs !== 64'hA5A5) begin errors++; $display("[TB] FAIL single_read got %h need a5a5", obs); end
        checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== '0) begin errors++; $display("[TB] FAIL single_drained got valid %b data %h need 0 0", bus.valid_out, bus.data_out); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL single_count_after got %0d need 0", bus.count); end
    endtask

    task automatic test_fill_overflow();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w;
        doReset(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, DATA_WIDTH'(i), 1'b0, rd, obs, exp_w);
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready got %b need 0", bus.ready_out); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count got %0d need 4", bus.count); end
        applyStimulus(1'b1, 64'd5, 1'b0, rd, obs, exp_w);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b need 1", bus.overflow); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got %0d need 4", bus.count); end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, rd, obs, exp_w);
            checks++;
            if (!rd || obs !== exp_w || obs !== DATA_WIDTH'(i)) begin
                errors++; $display("[TB] FAIL drain_order got %h need %h", obs, DATA_WIDTH'(i));
            end
        end
        checks++; if (bus.count !== 3'd0 || bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL drain_end got count %0d ovf %b need 0 1", bus.count, bus.overflow); end
    endtask

    task automatic test_full_read_write();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w;
        doReset(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, DATA_WIDTH'(i), 1'b0, rd, obs, exp_w);
        applyStimulus(1'b1, 64'd9, 1'b1, rd, obs, exp_w);
        checks++; if (!rd || obs !== 64'd1) begin errors++; $display("[TB] FAIL fullrw_head got %h need 1", obs); end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("[TB] FAIL fullrw_count got %0d need 3", bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL fullrw_ovf got %b need 1", bus.overflow); end
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, rd, obs, exp_w);
            checks++;
            if (!rd || obs !== exp_w || obs !== DATA_WIDTH'(i)) begin
                errors++; $display("[TB] FAIL fullrw_drain got %h need %h", obs, DATA_WIDTH'(i));
            end
        end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL fullrw_nine_dropped got valid %b need 0", bus.valid_out); end
    endtask

    task automatic test_empty_read();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w;
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, rd, obs, exp_w);
        checks++; if (bus.count !== 3'd0 || bus.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL empty_read got count %0d valid %b need 0 0", bus.count, bus.valid_out); end
        applyStimulus(1'b1, 64'h1234, 1'b1, rd, obs, exp_w);
        checks++; if (bus.count !== 3'd1 || bus.data_out !== 64'h1234) begin errors++; $display("[TB] FAIL empty_write got count %0d data %h need 1 1234", bus.count, bus.data_out); end
        applyStimulus(1'b0, '0, 1'b1, rd, obs, exp_w);
        checks++; if (!rd || obs !== exp_w) begin errors++; $display("[TB] FAIL empty_write_read got %h need %h", obs, exp_w); end
    endtask

    task automatic test_back_to_back();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w;
        doReset(1'b0, 1'b0);
        applyStimulus(1'b1, 64'd1, 1'b1, rd, obs, exp_w);
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 64'd1) begin errors++; $display("[TB] FAIL stream_latency got valid %b data %h need 1 1", bus.valid_out, bus.data_out); end
        for (int i = 2; i <= 11; i++) begin
            applyStimulus(i <= 10, DATA_WIDTH'(i), 1'b1, rd, obs, exp_w);
            checks++;
            if (!rd || obs !== exp_w || obs !== DATA_WIDTH'(i - 1)) begin
                errors++; $display("[TB] FAIL stream_order got %h need %h", obs, DATA_WIDTH'(i - 1));
            end
            checks++;
            if (bus.count > 3'd1 || bus.overflow !== 1'b0) begin
                errors++; $display("[TB] FAIL stream_state got count %0d ovf %b need <=1 0", bus.count, bus.overflow);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w;
        doReset(1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DATA_WIDTH'(i), 1'b0, rd, obs, exp_w);
        applyStimulus(1'b0, '0, 1'b1, rd, obs, exp_w);
        checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre got count %0d ovf %b need 3 1", bus.count, bus.overflow); end
        doReset(1'b1, 1'b1);
        checks++;
        if (bus.count !== 3'd0 || bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_state got count %0d valid %b ready %b ovf %b need 0 0 1 0",
                              bus.count, bus.valid_out, bus.ready_out, bus.overflow);
        end
        applyStimulus(1'b1, 64'h77, 1'b0, rd, obs, exp_w);
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 64'h77) begin errors++; $display("[TB] FAIL midrst_write got valid %b data %h need 1 77", bus.valid_out, bus.data_out); end
    endtask

    task automatic test_random();
        logic rd;
        logic [DATA_WIDTH-1:0] obs, exp_w, head;
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), rd, obs, exp_w);
            if (rd) begin
                checks++; if (obs !== exp_w) begin errors++; $display("[TB] FAIL rand_read got %h need %h", obs, exp_w); end
            end
            head = (sb.size() != 0) ? sb[0] : '0;
            checks++;
            if (bus.count !== CNT_WIDTH'(sb.size()) || bus.data_out !== head || bus.overflow !== mdl_ovf) begin
                errors++; $display("[TB] FAIL rand_state got count %0d data %h ovf %b need %0d %h %b",
                                  bus.count, bus.data_out, bus.overflow, sb.size(), head, mdl_ovf);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        mdl_ovf       = 1'b0;
        reset         = 1'b1;
        bus.enable_in = 1'b0;
        bus.ready_in  = 1'b0;
        bus.data_in   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_full_read_write();
        test_empty_read();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
